// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler that moves one packet per three cycles from a pending
// driver FIFO to its destination FIFO(s), with broadcast and drop counting.
module bus_rr_scheduler #(
    parameter int          PCKG_SZ   = 16,
    parameter int          DRVRS     = 8,
    parameter logic [7:0]  BROADCAST = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DRVRS-1:0]           pndng,
    input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
    output logic [DRVRS-1:0]           pop,
    output logic [DRVRS-1:0]           push,
    output logic [PCKG_SZ-1:0]         D_push,
    output logic                       busy,
    output logic [7:0]                 grant_id,
    output logic [7:0]                 drop_cnt
);

    localparam int WW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    typedef enum logic [1:0] {IDLE, POP, SEND} state_t;

    state_t               state_reg, state_next;
    logic [WW-1:0]        last_grant_reg, winner_reg, rr_winner;
    logic [DRVRS-1:0]     pop_reg, pop_next, push_reg, push_next;
    logic [PCKG_SZ-1:0]   d_push_reg, head_pkt;
    logic                 busy_reg;
    logic [7:0]           grant_id_reg, drop_cnt_reg, drop_cnt_next, dest;
    logic [PCKG_SZ-1:0]   head_arr [DRVRS];
    logic [DRVRS-1:0]     ucast_hit, bcast_mask;
    logic                 is_bcast, is_ucast;

    generate
        for (genvar gi = 0; gi < DRVRS; gi++) begin : g_drv
            assign head_arr[gi]   = D_pop[gi*PCKG_SZ +: PCKG_SZ];
            assign ucast_hit[gi]  = (dest == 8'(gi));
            assign bcast_mask[gi] = (winner_reg != WW'(gi));
        end
    endgenerate

    assign head_pkt = head_arr[winner_reg];
    assign dest     = head_pkt[PCKG_SZ-1 -: 8];
    assign is_bcast = (dest == BROADCAST);
    assign is_ucast = !is_bcast && (dest < 8'(DRVRS)) && (dest != 8'(winner_reg));

    // Two passes: requesters above last_grant override those at or below it,
    // so the lowest index above last_grant wins, else the lowest overall.
    always_comb begin
        rr_winner = '0;
        for (int i = DRVRS - 1; i >= 0; i--) begin
            if (pndng[i] && (i <= int'(last_grant_reg))) rr_winner = WW'(i);
        end
        for (int i = DRVRS - 1; i >= 0; i--) begin
            if (pndng[i] && (i > int'(last_grant_reg))) rr_winner = WW'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|pndng) state_next = POP;
            POP:     state_next = SEND;
            SEND:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop_next      = '0;
        push_next     = '0;
        drop_cnt_next = drop_cnt_reg;
        case (state_reg)
            IDLE: if (|pndng) pop_next = DRVRS'(1) << rr_winner;
            POP: begin
                if (is_bcast)                  push_next = bcast_mask;
                else if (is_ucast)             push_next = ucast_hit;
                else if (drop_cnt_reg != 8'hFF) drop_cnt_next = drop_cnt_reg + 8'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_reg        <= '0;
            push_reg       <= '0;
            d_push_reg     <= '0;
            busy_reg       <= 1'b0;
            grant_id_reg   <= '0;
            drop_cnt_reg   <= '0;
            winner_reg     <= '0;
            last_grant_reg <= WW'(DRVRS - 1);
        end else begin
            pop_reg      <= pop_next;
            push_reg     <= push_next;
            busy_reg     <= (state_next != IDLE);
            drop_cnt_reg <= drop_cnt_next;
            if (state_reg == IDLE && |pndng) winner_reg <= rr_winner;
            if (state_reg == POP) begin
                d_push_reg     <= head_pkt;
                grant_id_reg   <= 8'(winner_reg);
                last_grant_reg <= winner_reg;
            end
        end
    end

    assign pop      = pop_reg;
    assign push     = push_reg;
    assign D_push   = d_push_reg;
    assign busy     = busy_reg;
    assign grant_id = grant_id_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Self-checking bench for bus_rr_scheduler: directed scenarios plus random
// traffic compared against a transaction-level round-robin model.
module tb_bus_rr_scheduler;

    logic          clk;
    logic          reset;
    logic [7:0]    pndng;
    logic [127:0]  D_pop;
    logic [7:0]    pop, push;
    logic [15:0]   D_push;
    logic          busy;
    logic [7:0]    grant_id, drop_cnt;

    logic [15:0]   words [8];
    int            checks, failures;
    int            last_m, drops_m;

    bus_rr_scheduler #(.PCKG_SZ(16), .DRVRS(8), .BROADCAST(8'hFF)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push), .busy(busy),
        .grant_id(grant_id), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        D_pop = '0;
        for (int i = 0; i < 8; i++) D_pop[i*16 +: 16] = words[i];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next grant: first requester found walking upward from last+1, modulo 8.
    function automatic int rr_pick(input logic [7:0] req, input int last);
        int idx;
        for (int k = 1; k <= 8; k++) begin
            idx = (last + k) % 8;
            if (req[idx[2:0]]) return idx;
        end
        return 0;
    endfunction

    function automatic logic [7:0] model_push(input logic [7:0] dst, input int src);
        logic [7:0] src_bit;
        src_bit = 8'h01 << src;
        if (dst == 8'hFF) return ~src_bit;
        if (dst < 8'd8 && int'(dst) != src) return 8'h01 << dst;
        return 8'h00;
    endfunction

    // One full IDLE->POP->SEND->IDLE transfer; caller is in an IDLE cycle.
    task automatic txn(input logic [7:0] req, input bit hold, output int w);
        logic [15:0] pkt;
        logic [7:0]  exp_push;
        w        = rr_pick(req, last_m);
        pkt      = words[w];
        exp_push = model_push(pkt[15:8], w);
        pndng    = req;
        tick();
        check("pop_strobe", pop, 8'h01 << w);
        check("pop_busy", busy, 1);
        check("pop_nopush", push, 0);
        if (!hold) pndng = 8'($urandom);
        tick();
        if (exp_push == 8'h00 && drops_m < 255) drops_m++;
        last_m = w;
        check("send_push", push, exp_push);
        check("send_data", D_push, pkt);
        check("send_grant", grant_id, w);
        check("send_nopop", pop, 0);
        check("send_drops", drop_cnt, drops_m);
        check("send_busy", busy, 1);
        if (!hold) pndng = 8'h00;
        tick();
        check("idle_busy", busy, 0);
        check("idle_push", push, 0);
        check("idle_pop", pop, 0);
        check("idle_hold", D_push, pkt);
    endtask

    initial begin
        int w;
        int r;
        int src;
        logic [7:0] dst;
        checks   = 0;
        failures = 0;
        last_m   = 7;
        drops_m  = 0;
        for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
        reset = 1'b1;
        pndng = 8'h00;

        // Reset asserted between clock edges with arbitrary requests.
        #2 reset = 1'b0;
        pndng = 8'($urandom) | 8'h01;
        #1;
        check("rst_pop", pop, 0);
        check("rst_push", push, 0);
        check("rst_dpush", D_push, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_drops", drop_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold_pop", pop, 0);
            check("rst_hold_busy", busy, 0);
            check("rst_hold_push", push, 0);
        end
        pndng = 8'h00;
        reset = 1'b1;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_empty_pop", pop, 0);
            check("idle_empty_busy", busy, 0);
        end

        // Unicast 2 -> 5, then broadcast from 3.
        words[2] = 16'h0511;
        txn(8'h04, 1'b0, w);
        check("ucast_grant", grant_id, 2);
        words[3] = 16'hFFAB;
        txn(8'h08, 1'b0, w);
        check("bcast_grant", grant_id, 3);

        // Reset during POP of driver 5 aborts the transfer.
        words[5] = 16'h0377;
        pndng = 8'h20;
        tick();
        check("abort_pop_pre", pop, 8'h20);
        #2 reset = 1'b0;
        #1;
        check("abort_pop", pop, 0);
        check("abort_push", push, 0);
        check("abort_busy", busy, 0);
        check("abort_grant", grant_id, 0);
        pndng = 8'h21;
        tick();
        tick();
        check("abort_hold_push", push, 0);
        check("abort_hold_pop", pop, 0);
        reset   = 1'b1;
        last_m  = 7;
        drops_m = 0;
        words[0] = 16'h0455;
        txn(8'h21, 1'b0, w);
        check("abort_first_grant", grant_id, 0);
        check("abort_first_push", push, 0);

        // Fairness with every driver requesting continuously.
        last_m = 0;
        reset  = 1'b0;
        #1 reset = 1'b1;
        last_m = 7;
        for (int i = 0; i < 8; i++) words[i] = {8'((i + 1) % 8), 8'($urandom)};
        for (int i = 0; i < 9; i++) begin
            txn(8'hFF, 1'b1, w);
            check("fair_seq", grant_id, i % 8);
        end
        pndng = 8'h00;
        tick();
        tick();
        tick();

        // Drops: out-of-range destination, then self-addressed.
        words[1] = 16'h0933;
        txn(8'h02, 1'b0, w);
        check("drop_one", drop_cnt, 1);
        words[2] = 16'h0244;
        txn(8'h04, 1'b0, w);
        check("drop_two", drop_cnt, 2);
        for (int i = 0; i < 300; i++) begin
            src = $urandom_range(0, 7);
            dst = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8, 254)) : 8'(src);
            words[src] = {dst, 8'($urandom)};
            txn(8'h01 << src, 1'b0, w);
        end
        check("drop_saturate", drop_cnt, 255);

        // Random traffic against the model.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 8; i++) begin
                r = $urandom_range(0, 3);
                if (r == 0)      dst = 8'hFF;
                else if (r == 1) dst = 8'($urandom_range(8, 254));
                else             dst = 8'($urandom_range(0, 7));
                words[i] = {dst, 8'($urandom)};
            end
            txn(8'($urandom_range(1, 255)), 1'b0, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_rr_scheduler.md
BUS_RR_SCHEDULER -- requirements
Module: bus_rr_scheduler

Interface
REQ-001 The block SHALL have parameter PCKG_SZ, default 16, packet width in bits (minimum 9).
REQ-002 The block SHALL have parameter DRVRS, default 8, number of driver FIFOs sharing the bus (2..255).
REQ-003 The block SHALL have parameter BROADCAST, default 8'hFF, destination ID meaning all drivers.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port pndng  input  DRVRS  bit i high = driver i FIFO holds at least one packet.
REQ-007 The block SHALL have port D_pop  input  DRVRS*PCKG_SZ  head packet of driver i on bits [i*PCKG_SZ +: PCKG_SZ].
REQ-008 The block SHALL have port pop  output  DRVRS  one-hot, one-cycle pop strobe to the granted driver FIFO.
REQ-009 The block SHALL have port push  output  DRVRS  push strobe(s) to destination driver(s).
REQ-010 The block SHALL have port D_push  output  PCKG_SZ  packet delivered to destination(s).
REQ-011 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 The block SHALL have port grant_id  output  8  index of the most recently granted driver.
REQ-013 The block SHALL have port drop_cnt  output  8  count of dropped packets, saturating at 255.

Function
REQ-014 The block SHALL implement states IDLE, POP and SEND; every output is registered.
REQ-015 In IDLE with pndng==0, the block SHALL remain in IDLE with pop and push held at 0.
REQ-016 In IDLE with any pndng bit set, the block SHALL select the winner by round-robin, searching upward from (last_grant+1) mod DRVRS, and enter POP.
REQ-017 In POP, the block SHALL assert pop[winner] for exactly one cycle, capture D_pop of the winner into the packet register, update grant_id and last_grant, and enter SEND.
REQ-018 Destination SHALL be packet bits [PCKG_SZ-1 -: 8]; remaining bits are payload, carried unchanged.
REQ-019 In SEND with destination == BROADCAST, the block SHALL assert push for every driver except the source, for one cycle.
REQ-020 In SEND with destination < DRVRS and destination != source, the block SHALL assert push[destination] only, for one cycle.
REQ-021 In SEND with destination >= DRVRS (not BROADCAST) or destination == source, the block SHALL assert no push and increment drop_cnt (held at 255 once reached).
REQ-022 D_push SHALL equal the captured packet during SEND and hold that value until the next SEND.
REQ-023 After SEND, the block SHALL return to IDLE; it SHALL NOT grant again until the next IDLE cycle, giving throughput of 1 packet per 3 cycles.
REQ-024 Latency: pndng sampled high in IDLE at cycle t SHALL produce pop at t+1 and push at t+2.
REQ-025 pndng changes during POP or SEND SHALL NOT alter the committed grant; the source keeps pndng high until popped (environment obligation).
REQ-026 Round-robin search SHALL wrap from DRVRS-1 to 0; a lone requester is granted on every arbitration.

Reset
REQ-027 While reset is low, the block SHALL force state=IDLE, pop=0, push=0, D_push=0, busy=0, grant_id=0, drop_cnt=0 and last_grant=DRVRS-1, independent of clk.
REQ-028 Reset asserted mid-POP or mid-SEND SHALL abort the transfer immediately with no further pop or push; the captured packet is discarded.
REQ-029 After reset deasserts, the first arbitration SHALL give driver 0 highest priority.

Verification (PCKG_SZ=16, DRVRS=8, BROADCAST=8'hFF)
REQ-030 Reset: drive reset=0 with arbitrary pndng -> all outputs 0 at once, and they stay 0 while reset is low.
REQ-031 Unicast: pndng=8'h04, D_pop[2]=16'h0511 -> pop=8'h04 at t+1; push=8'h20 and D_push=16'h0511 at t+2; busy high for 2 cycles.
REQ-032 Broadcast: pndng=8'h08, D_pop[3]=16'hFFAB -> pop=8'h08, then push=8'hF7 with D_push=16'hFFAB.
REQ-033 Fairness: pndng=8'hFF held for 27 cycles -> grant_id sequence 0,1,...,7,0 with one grant per 3 cycles and never two pop bits set.
REQ-034 Drop: packets with destination 8'h09 and destination==source -> pop issued, push stays 0, drop_cnt 0->1->2; after 300 drops drop_cnt = 255.
REQ-035 Reset mid-transfer: reset low during POP of driver 5 -> pop and push go to 0 immediately; after release with pndng=8'h21, driver 0 is granted first.
